// File: rtl/uart_debug_ctrl_pkg.sv
// Shared definitions for the UART debug controller: FSM encoding, command bytes, status layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_debug_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_STEP    = 3'd2,
        ST_RUN     = 3'd3,
        ST_LATCH   = 3'd4,
        ST_SEND    = 3'd5,
        ST_WAIT_TX = 3'd6
    } dbg_state_t;

    // ASCII command bytes accepted from the host
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

    // Status byte layout (first byte of every frame); bits above the command field are zero
    localparam int STAT_HALT    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_CMD_LSB = 2;
    localparam int STAT_CMD_W   = 2;

    localparam logic [1:0] CODE_STEP = 2'b01;
    localparam logic [1:0] CODE_CONT = 2'b10;
    localparam logic [1:0] CODE_DUMP = 2'b11;

    // Map a command byte onto its two-bit status code (zero for unknown bytes)
    function automatic logic [1:0] cmd_code(input logic [7:0] cmd);
        logic [1:0] code;
        code = 2'b00;
        if (cmd == CMD_STEP)      code = CODE_STEP;
        else if (cmd == CMD_CONT) code = CODE_CONT;
        else if (cmd == CMD_DUMP) code = CODE_DUMP;
        return code;
    endfunction

endpackage

// File: rtl/dbg_byte_serializer.sv
// Shifts a status byte plus a zero-padded snapshot out to the UART TX, LSB byte first.
// Latency: tx_start rises the cycle after load; each later byte one cycle after the previous ack.
// Backpressure: holds tx_start and the byte until tx_ack, then drops tx_start for one cycle.
module dbg_byte_serializer
    import uart_debug_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEBUG_W   = 322,
    parameter int NUM_BYTES = (DEBUG_W + DATA_W - 1) / DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DEBUG_W-1:0] snapshot,
    input  logic [DATA_W-1:0]  status,
    input  logic               tx_ack,
    output logic [DATA_W-1:0]  tx_dato_in,
    output logic               tx_start,
    output logic               done
);

    localparam int SNAP_W = NUM_BYTES * DATA_W;
    localparam int BUF_W  = (NUM_BYTES + 1) * DATA_W;
    localparam int CNT_W  = $clog2(NUM_BYTES + 2);

    logic [SNAP_W-1:0] snap_pad;
    logic [BUF_W-1:0]  frame_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_q;

    // Upper pad bits of the last snapshot byte are zero
    assign snap_pad = SNAP_W'(snapshot);

    // Frame buffer, remaining-byte counter and TX request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else if (load) begin
            frame_q <= {snap_pad, status};
            cnt_q   <= CNT_W'(NUM_BYTES + 1);
            start_q <= 1'b1;
        end else if (tx_ack && start_q) begin
            frame_q <= frame_q >> DATA_W;
            cnt_q   <= cnt_q - 1'b1;
            start_q <= 1'b0;
        end else if (!start_q && (cnt_q != '0)) begin
            start_q <= 1'b1;
        end
    end

    assign tx_dato_in = frame_q[DATA_W-1:0];
    assign tx_start   = start_q;
    assign done       = tx_ack && start_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_debug_ctrl.sv
// Host-driven debug controller: decodes step/continue/dump commands and dumps a status+snapshot frame.
// Latency: step enable pulse to first tx_start is 2 cycles; command capture to decode is 1 cycle.
// Backpressure: one command at a time; rx_done while busy is dropped, TX paced by tx_done.
module uart_debug_ctrl
    import uart_debug_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEBUG_W = 322,
    parameter int RUN_MAX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  rx_dato_out,
    input  logic               rx_done,
    input  logic               tx_done,
    input  logic [DEBUG_W-1:0] debug_signal,
    input  logic               halt,
    output logic               enable,
    output logic [DATA_W-1:0]  tx_dato_in,
    output logic               tx_start,
    output logic               busy
);

    localparam int NUM_BYTES = (DEBUG_W + DATA_W - 1) / DATA_W;

    dbg_state_t        state_q, state_d;
    logic [DATA_W-1:0] cmd_q;
    logic              timeout_q;
    logic [31:0]       run_cnt_q;
    logic              run_last;
    logic              run_timeout;
    logic              ser_load;
    logic              ser_done;
    logic              tx_ack;
    logic [DATA_W-1:0] status;

    assign run_last = (RUN_MAX != 0) && (run_cnt_q == 32'(RUN_MAX - 1));
    assign tx_ack   = tx_done && (state_q == ST_WAIT_TX);
    assign busy     = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and processor-enable decode
    always_comb begin
        state_d     = state_q;
        enable      = 1'b0;
        ser_load    = 1'b0;
        run_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cmd_q == DATA_W'(CMD_STEP))      state_d = ST_STEP;
                else if (cmd_q == DATA_W'(CMD_CONT)) state_d = ST_RUN;
                else if (cmd_q == DATA_W'(CMD_DUMP)) state_d = ST_LATCH;
                else                                 state_d = ST_IDLE;
            end
            ST_STEP: begin
                enable  = 1'b1;
                state_d = ST_LATCH;
            end
            ST_RUN: begin
                // halt gates enable combinationally so a halted core never gets an extra cycle
                if (halt) begin
                    state_d = ST_LATCH;
                end else begin
                    enable = 1'b1;
                    if (run_last) begin
                        run_timeout = 1'b1;
                        state_d     = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) state_d = ser_done ? ST_IDLE : ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture, run-length counter and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            timeout_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && rx_done) begin
                cmd_q     <= rx_dato_out;
                timeout_q <= 1'b0;
            end
            if (state_q == ST_DECODE)
                run_cnt_q <= '0;
            else if (state_q == ST_RUN && enable)
                run_cnt_q <= run_cnt_q + 32'd1;
            if (run_timeout)
                timeout_q <= 1'b1;
        end
    end

    // Status byte assembled from the live halt input during LATCH
    always_comb begin
        status = '0;
        status[STAT_HALT]    = halt;
        status[STAT_TIMEOUT] = timeout_q;
        status[STAT_CMD_LSB +: STAT_CMD_W] = cmd_code(8'(cmd_q));
    end

    dbg_byte_serializer #(
        .DATA_W    (DATA_W),
        .DEBUG_W   (DEBUG_W),
        .NUM_BYTES (NUM_BYTES)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .snapshot   (debug_signal),
        .status     (status),
        .tx_ack     (tx_ack),
        .tx_dato_in (tx_dato_in),
        .tx_start   (tx_start),
        .done       (ser_done)
    );

endmodule

// File: tb/tb_uart_debug_ctrl.sv
module tb_uart_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_dato = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic [19:0] debug = 20'h0;
    logic        sel = 1'b0;     // 0: unlimited-run DUT, 1: RUN_MAX=16 DUT
    logic        halt;

    // Processor model: halt forced, or raised once hat_r enabled cycles have elapsed
    bit hf_r = 1'b0;
    bit ha_r = 1'b0;
    int hat_r = 0;

    int cyc = 0, en_cnt = 0, busy_cnt = 0, first_en = -1, first_tx = -1;
    int n_checks = 0, n_fail = 0;
    logic [7:0] got_q[$];

    logic       rx_done_a, rx_done_b;
    logic       en_a, txs_a, busy_a, en_b, txs_b, busy_b;
    logic [7:0] txd_a, txd_b;
    logic       cur_enable, cur_tx_start, cur_busy;
    logic [7:0] cur_txd;

    assign rx_done_a = rx_done & ~sel;
    assign rx_done_b = rx_done & sel;
    assign halt = hf_r | (ha_r && (en_cnt >= hat_r));
    assign cur_enable   = sel ? en_b   : en_a;
    assign cur_tx_start = sel ? txs_b  : txs_a;
    assign cur_busy     = sel ? busy_b : busy_a;
    assign cur_txd      = sel ? txd_b  : txd_a;

    uart_debug_ctrl #(.DATA_W(8), .DEBUG_W(20), .RUN_MAX(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_dato_out(rx_dato), .rx_done(rx_done_a),
        .tx_done(tx_done), .debug_signal(debug), .halt(halt),
        .enable(en_a), .tx_dato_in(txd_a), .tx_start(txs_a), .busy(busy_a));

    uart_debug_ctrl #(.DATA_W(8), .DEBUG_W(20), .RUN_MAX(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_dato_out(rx_dato), .rx_done(rx_done_b),
        .tx_done(tx_done), .debug_signal(debug), .halt(halt),
        .enable(en_b), .tx_dato_in(txd_b), .tx_start(txs_b), .busy(busy_b));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (cur_enable) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
        end
        if (cur_tx_start && first_tx < 0) first_tx = cyc;
        if (cur_busy) busy_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // UART TX stand-in: accepts bytes with a random delay, checks hold and gap
    task automatic collect_frame(input bit inject, output bit timed_out);
        int guard;
        int d;
        logic [7:0] b;
        got_q.delete();
        timed_out = 1'b0;
        guard = 0;
        while (cur_busy && guard < 3000) begin
            if (!cur_tx_start) begin
                @(negedge clk);
                guard++;
            end else begin
                b = cur_txd;
                got_q.push_back(b);
                d = $urandom_range(1, 4);
                for (int k = 0; k < d; k++) begin
                    if (inject && got_q.size() == 2 && k == 0) begin
                        rx_dato = 8'h73;
                        rx_done = 1'b1;
                    end
                    @(negedge clk);
                    rx_done = 1'b0;
                    n_checks++;
                    if (cur_tx_start !== 1'b1 || cur_txd !== b) begin
                        n_fail++;
                        $display("FAIL tx_hold: tx_start=%b tx_dato_in=%h, required 1 and %h",
                                 cur_tx_start, cur_txd, b);
                    end
                end
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                n_checks++;
                if (cur_tx_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_gap: tx_start=%b after tx_done, required 0", cur_tx_start);
                end
                guard++;
            end
        end
        if (guard >= 3000) timed_out = 1'b1;
    endtask

    // Issue one command and compare the frame and enable activity with the reference model
    task automatic run_cmd(input bit s, input logic [7:0] cmd, input logic [19:0] dbg,
                           input bit hf, input bit ha, input int hat, input bit inject,
                           input string name);
        int run_max, exp_en, extra;
        bit known, is_c, exp_to, exp_halt, tmo;
        logic [1:0] code;
        logic [7:0] exp_b[4];
        run_max = s ? 16 : 0;
        is_c  = (cmd == 8'h63);
        known = (cmd == 8'h73) || is_c || (cmd == 8'h64);
        code  = (cmd == 8'h73) ? 2'd1 : is_c ? 2'd2 : 2'd3;
        if (cmd == 8'h73)  exp_en = 1;
        else if (!is_c)    exp_en = 0;
        else if (hf)       exp_en = 0;
        else if (ha && (run_max == 0 || hat < run_max)) exp_en = hat;
        else               exp_en = run_max;
        exp_to   = is_c && !hf && run_max != 0 && (!ha || hat > run_max);
        exp_halt = hf || (ha && exp_en >= hat);
        exp_b[0] = {4'b0000, code, exp_to, exp_halt};
        for (int i = 1; i < 4; i++) exp_b[i] = 8'(dbg >> (8 * (i - 1)));

        @(negedge clk);
        sel = s; debug = dbg; hf_r = hf; ha_r = ha; hat_r = hat;
        en_cnt = 0; busy_cnt = 0; first_en = -1; first_tx = -1;
        rx_dato = cmd; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        collect_frame(inject, tmo);
        n_checks++;
        if (tmo) begin
            n_fail++;
            $display("FAIL %s_timeout: frame did not complete within cycle budget", name);
        end
        n_checks++;
        if (got_q.size() != (known ? 4 : 0)) begin
            n_fail++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, got_q.size(), known ? 4 : 0);
        end
        if (known) begin
            for (int i = 0; i < 4; i++) begin
                if (got_q.size() > i) begin
                    n_checks++;
                    if (got_q[i] !== exp_b[i]) begin
                        n_fail++;
                        $display("FAIL %s_byte%0d: got %h, required %h", name, i, got_q[i], exp_b[i]);
                    end
                end
            end
        end else begin
            n_checks++;
            if (busy_cnt != 1) begin
                n_fail++;
                $display("FAIL %s_busy: busy cycles %0d, required 1", name, busy_cnt);
            end
        end
        n_checks++;
        if (en_cnt != exp_en) begin
            n_fail++;
            $display("FAIL %s_enable: enable cycles %0d, required %0d", name, en_cnt, exp_en);
        end
        if (cmd == 8'h73) begin
            n_checks++;
            if (first_tx - first_en != 2) begin
                n_fail++;
                $display("FAIL %s_latency: enable->tx_start %0d cycles, required 2", name, first_tx - first_en);
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (cur_tx_start) extra++;
        end
        n_checks++;
        if (extra != 0 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: tx_start cycles %0d busy %b, required 0 and 0", name, extra, cur_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({en_a, txs_a, busy_a, txd_a, en_b, txs_b, busy_b, txd_b} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%b%b%b/%h b=%b%b%b/%h, required all zero",
                     en_a, txs_a, busy_a, txd_a, en_b, txs_b, busy_b, txd_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_step();
        run_cmd(1'b0, 8'h73, 20'hABCDE, 1'b1, 1'b0, 0, 1'b0, "step");
    endtask

    task automatic test_continue();
        run_cmd(1'b0, 8'h63, 20'h13579, 1'b0, 1'b1, 50, 1'b0, "continue");
        run_cmd(1'b0, 8'h63, 20'h2468A, 1'b1, 1'b0, 0, 1'b0, "halted_run");
        run_cmd(1'b0, 8'h64, 20'hFEDCB, 1'b0, 1'b0, 0, 1'b0, "dump");
    endtask

    task automatic test_timeout();
        run_cmd(1'b1, 8'h63, 20'h0F0F0, 1'b0, 1'b0, 0, 1'b0, "timeout");
        run_cmd(1'b1, 8'h73, 20'h55AA5, 1'b0, 1'b0, 0, 1'b0, "timeout_clear");
        run_cmd(1'b1, 8'h63, 20'h12345, 1'b0, 1'b1, 5, 1'b0, "timeout_halt");
    endtask

    task automatic test_ignore();
        run_cmd(1'b0, 8'h78, 20'h11111, 1'b0, 1'b0, 0, 1'b0, "ignore_x");
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b0, 8'h73, 20'h9ABCD, 1'b0, 1'b0, 0, 1'b1, "rx_while_busy");
    endtask

    task automatic test_reset_mid_frame();
        int seen, guard;
        @(negedge clk);
        sel = 1'b0; hf_r = 1'b0; ha_r = 1'b0; debug = 20'h31415;
        rx_dato = 8'h64; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        seen = 0; guard = 0;
        while (seen < 2 && guard < 200) begin
            if (txs_a) begin
                seen++;
                if (seen == 2) break;
                @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        n_checks++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL midframe_reach: tx_start seen %0d times, required 2", seen);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txs_a, busy_a, en_a, txd_a} !== 11'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: tx_start=%b busy=%b enable=%b tx_dato_in=%h, required all zero",
                     txs_a, busy_a, en_a, txd_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b0, 8'h64, 20'(($urandom)), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, "post_reset_dump");
    endtask

    task automatic test_random();
        bit s, hf;
        int r, hat;
        logic [7:0] cmd;
        for (int it = 0; it < 10; it++) begin
            s  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 3);
            cmd = (r == 0) ? 8'h73 : (r == 1) ? 8'h63 : (r == 2) ? 8'h64 : 8'($urandom_range(0, 255));
            hf = ($urandom_range(0, 3) == 0);
            hat = $urandom_range(1, 40);
            if (s && hat == 16) hat = 17;
            run_cmd(s, cmd, 20'($urandom), hf, 1'b1, hat, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_continue();
        test_timeout();
        test_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
